// File: rtl/dot_product_sequencer_pkg.sv
// Shared types and width helpers for the dot-product sequencer.
// Imported by the sequencer, its accumulator and its interface.
package dot_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    localparam int LANES = 8;

    function automatic int pp_size(input int in0, input int in1);
        return in0 + in1;
    endfunction

    function automatic int dp_out_size(input int in0, input int in1);
        return pp_size(in0, in1) + 8;
    endfunction

endpackage

// File: rtl/dot_product_sequencer_if.sv
// Operand beat stream and result stream of the dot-product sequencer.
// The sequencer is the slave; the feeding/consuming side is the master.
interface dot_product_sequencer_if
    import dot_seq_pkg::*;
#(
    parameter int IN_SIZE_0 = 4,
    parameter int IN_SIZE_1 = 8,
    parameter int ACC_SIZE  = 32
);

    logic                 a_valid;
    logic                 a_ready;
    logic [IN_SIZE_0-1:0] a_0 [LANES];
    logic [IN_SIZE_1-1:0] a_1 [LANES];

    logic                 res_valid;
    logic                 res_ready;
    logic [ACC_SIZE-1:0]  res;
    logic                 ovf;

    modport master (
        output a_valid, a_0, a_1, res_ready,
        input  a_ready, res_valid, res, ovf
    );

    modport slave (
        input  a_valid, a_0, a_1, res_ready,
        output a_ready, res_valid, res, ovf
    );

endinterface

// File: rtl/dot_product_sequencer_acc.sv
// Resolves a datapath sum/carry pair, sign-extends it and accumulates it
// with a sticky signed-overflow flag.
module dot_acc #(
    parameter int DP_W     = 20,
    parameter int ACC_SIZE = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en,
    input  logic                clr,
    input  logic [DP_W-1:0]     sum,
    input  logic [DP_W-1:0]     carry,
    output logic [ACC_SIZE-1:0] acc,
    output logic                ovf
);

    logic [DP_W-1:0]     partial;
    logic [ACC_SIZE-1:0] ext;
    logic [ACC_SIZE-1:0] nxt;
    logic                ovf_add;

    always_comb begin
        partial = sum + carry;
        ext     = ACC_SIZE'($signed(partial));
        nxt     = acc + ext;
        // same-sign operands giving a result of the other sign
        ovf_add = (acc[ACC_SIZE-1] == ext[ACC_SIZE-1]) &&
                  (nxt[ACC_SIZE-1] != acc[ACC_SIZE-1]);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (en) begin
            acc <= nxt;
            ovf <= ovf | ovf_add;
        end
    end

endmodule

// File: rtl/dot_product_sequencer.sv
// Feeds operand beats to the 2-stage multiply/compress datapath and
// accumulates its sum/carry output into one signed result per job.
module dot_product_sequencer
    import dot_seq_pkg::*;
#(
    parameter int IN_SIZE_0 = 4,
    parameter int IN_SIZE_1 = 8,
    parameter int ACC_SIZE  = 32,
    parameter int LEN_SIZE  = 16,
    localparam int DP_W     = dp_out_size(IN_SIZE_0, IN_SIZE_1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [LEN_SIZE-1:0]  len_i,
    output logic                 busy_o,
    output logic [IN_SIZE_0-1:0] dp_in_0_o [LANES],
    output logic [IN_SIZE_1-1:0] dp_in_1_o [LANES],
    input  logic [DP_W-1:0]      dp_out_i  [2],
    dot_product_sequencer_if.slave bus
);

    state_e              state;
    logic [LEN_SIZE-1:0] len_q;
    logic [LEN_SIZE-1:0] issued;
    logic [LEN_SIZE-1:0] issued_nxt;
    logic [1:0]          v;
    logic                a_ready_q;
    logic                res_valid_q;
    logic                busy_q;
    logic                fire;
    logic                clr;
    logic [ACC_SIZE-1:0] acc;
    logic                ovf;

    assign fire       = bus.a_valid & a_ready_q;
    assign clr        = (state == IDLE) & start_i;
    assign issued_nxt = issued + LEN_SIZE'(1);

    // idle lanes are forced to zero so bubbles contribute nothing
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            dp_in_0_o[i] = fire ? bus.a_0[i] : '0;
            dp_in_1_o[i] = fire ? bus.a_1[i] : '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            len_q       <= '0;
            issued      <= '0;
            v           <= '0;
            a_ready_q   <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            v <= {v[0], fire};
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        len_q  <= len_i;
                        issued <= '0;
                        busy_q <= 1'b1;
                        if (len_i == '0) begin
                            state       <= DONE;
                            res_valid_q <= 1'b1;
                        end else begin
                            state     <= RUN;
                            a_ready_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (fire) begin
                        issued <= issued_nxt;
                        if (issued_nxt == len_q) begin
                            state     <= DRAIN;
                            a_ready_q <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    // last pending partial lands on this same edge
                    if (!v[0]) begin
                        state       <= DONE;
                        res_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        state       <= IDLE;
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    dot_acc #(
        .DP_W     (DP_W),
        .ACC_SIZE (ACC_SIZE)
    ) u_acc (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (v[1]),
        .clr   (clr),
        .sum   (dp_out_i[0]),
        .carry (dp_out_i[1]),
        .acc   (acc),
        .ovf   (ovf)
    );

    assign busy_o        = busy_q;
    assign bus.a_ready   = a_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res       = acc;
    assign bus.ovf       = ovf;

endmodule
